stencil3x3_stream_filter: RTL and testbench
===========================================

Name: stencil3x3_stream_filter

Overview:
- Parametrised successor to the fixed Laplacian stencil datapath: streaming 3x3 image filter on raster-order, packed multi-pixel words.
- Adds valid/ready handshakes with backpressure, selectable kernel mode latched per frame, generic frame size and pixels-per-word, and an end-of-frame drain.
- Sits between the pixel source (memory reader) and the result writer.
- Border pixels pass through unchanged.

Parameters:
- PIX_W, 8, bits per pixel (unsigned).
- PPW, 2, pixels per word; pixel 0 (leftmost) in the most significant PIX_W bits.
- FRAME_W, 128, pixels per line; must be a multiple of PPW and at least 2*PPW.
- FRAME_H, 128, lines per frame; must be at least 3.
- ACC_W, PIX_W+6, signed accumulator width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- mode  in  2  kernel select, sampled on the first accepted word of each frame: 0 passthrough, 1 Laplacian, 2 Gaussian, 3 sharpen.
- s_data  in  PIX_W*PPW  input pixel word.
- s_valid  in  1  input word valid.
- s_ready  out  1  block accepts input this cycle.
- m_data  out  PIX_W*PPW  filtered pixel word.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts output.
- m_last  out  1  marks the final output word of the frame.
- busy  out  1  frame in progress, including drain.

Behaviour:
- Reset values: s_ready=0, m_valid=0, m_last=0, m_data=0, busy=0. Line buffers, counters and pipeline are cleared. Reset mid-frame aborts the frame with no partial output. The next frame starts clean.
- Stall: adv = !m_valid || m_ready. The whole pipeline and the line buffers advance only when adv=1 and a slot is present (input accepted or drain slot).
- Transfer rule: a transfer occurs when valid && ready. m_data and m_last hold stable while m_valid && !m_ready.
- FSM IDLE:
  - s_ready = adv; busy=0.
  - The first accept latches mode into mode_q, zeroes the column and row counters, and moves to RUN.
- FSM RUN:
  - s_ready = adv; busy=1.
  - Each accept advances col (wraps at FRAME_W/PPW-1) and row.
  - The accept of word FRAME_W*FRAME_H/PPW-1 moves to DRAIN.
- FSM DRAIN:
  - s_ready=0.
  - Inject WPL+1 zero-data slots (WPL=FRAME_W/PPW), one per adv cycle.
  - After the last slot leaves the pipeline and m_last transfers, return to IDLE.
- Windowing: two line buffers, each WPL words deep. Output word k (raster index) is formed when slot k+WPL+1 enters. Registered stages: multiply, row sums, total+normalise/clamp.
- Latency: with m_ready=1 and no bubbles, m_valid for word k asserts 3 cycles after slot k+WPL+1 enters.
- Exactly FRAME_W*FRAME_H/PPW output words per frame, in order. m_last is set only on the last one.
- Border pixels (row 0, row FRAME_H-1, pixel column 0, pixel column FRAME_W-1): output = input pixel, unfiltered. This is evaluated per pixel within a word.
- Kernels (row-major):
  - mode 1: -1 -1 -1 / -1 8 -1 / -1 -1 -1, shift 0.
  - mode 2: 1 2 1 / 2 4 2 / 1 2 1, add 8 then shift 4.
  - mode 3: 0 -1 0 / -1 5 -1 / 0 -1 0, shift 0.
  - mode 0: output = centre pixel.
- Arithmetic:
  - Pixels are zero-extended to ACC_W signed. Sums are in ACC_W signed with no overflow for the given kernels.
  - Shift is arithmetic right.
  - Clamp: negative -> 0; >= 2^PIX_W-1 -> 2^PIX_W-1; otherwise the low PIX_W bits.
- Mode changes on the mode input during RUN/DRAIN are ignored until the next frame start.
- Back-to-back frames: input is not accepted during DRAIN. The first word after returning to IDLE starts a new frame.

Test Plan:
(FRAME_W=8, FRAME_H=4, PPW=2, PIX_W=8 unless stated.)
- Flat frame, all pixels 100, mode 1, m_ready=1 -> interior outputs 0, border 100. Exactly 16 words out; m_last on word 15 only; busy falls after it.
- All 0 except pixel (row1,col3)=255, mode 1 -> (1,3)=255 (clamp of 2040); its interior neighbours 0 (negative clamp); borders unchanged.
- Flat 100, mode 2 -> all outputs 100. Single interior pixel 160 in zeros -> centre (640+8)>>4 = 40, edge-adjacent interior neighbours 20, diagonal neighbours 10.
- mode 3, interior pixel 60 with its four neighbours at 50 -> 100; centre 10 with its four neighbours at 50 -> 0 (clamped).
- Random frame with m_ready toggled pseudo-randomly and s_valid gaps -> output stream bit-identical to a reference model. m_data held while stalled; no word lost or duplicated.
- Assert rst for 1 cycle after 7 accepted words -> m_valid=0 and busy=0 next cycle. A following full flat-100 mode-0 frame outputs 16 words of 100.

Source files
------------

// File: rtl/stencil3x3_stream_filter.sv
// Streaming 3x3 kernel filter over raster-order packed pixel words with valid/ready flow control.
// Two line buffers feed a 3x3-word window; a multiply / row-sum / total-clamp pipeline follows.
module stencil3x3_stream_filter #(
  parameter int PIX_W   = 8,
  parameter int PPW     = 2,
  parameter int FRAME_W = 128,
  parameter int FRAME_H = 128,
  parameter int ACC_W   = PIX_W + 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic [PIX_W*PPW-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [PIX_W*PPW-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic                 busy
);
  localparam int DW     = PIX_W * PPW;
  localparam int WPL    = FRAME_W / PPW;
  localparam int NW     = WPL * FRAME_H;
  localparam int SLOT_W = $clog2(NW + WPL + 2);
  localparam int PTR_W  = $clog2(WPL);
  localparam int COL_W  = $clog2(WPL);
  localparam int ROW_W  = $clog2(FRAME_H);
  localparam int DL_W   = $clog2(WPL + 2);
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIX_W) - 1);

  // state | meaning
  // IDLE  | waiting for the first word of a frame
  // RUN   | accepting frame words
  // DRAIN | injecting zero slots to flush the window, then waiting for m_last
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2;

  logic [1:0]        state, mode_q;
  logic [SLOT_W-1:0] slot_idx;
  logic [DL_W-1:0]   drain_left;
  logic [COL_W-1:0]  oc_col;
  logic [ROW_W-1:0]  oc_row;
  logic [PTR_W-1:0]  lb_ptr;
  logic [DW-1:0]     lb1 [WPL];
  logic [DW-1:0]     lb2 [WPL];
  logic [DW-1:0]     win [3][3];
  logic [3*DW-1:0]   rowcat [3];
  logic              adv, acc, drain_slot, slot, formed;
  logic [DW-1:0]     slot_data;
  logic              w_v, w_last;
  logic [PPW-1:0]    w_bord, bord_nxt;

  logic signed [ACC_W-1:0] prod_nxt [PPW][3][3];
  logic signed [ACC_W-1:0] s1_prod [PPW][3][3];
  logic signed [ACC_W-1:0] s2_row [PPW][3];
  logic signed [ACC_W-1:0] tot [PPW];
  logic signed [ACC_W-1:0] norm [PPW];
  logic [PIX_W-1:0]        ctr_nxt [PPW];
  logic [PIX_W-1:0]        s1_ctr [PPW];
  logic [PIX_W-1:0]        s2_ctr [PPW];
  logic [PIX_W-1:0]        res [PPW];
  logic [PPW-1:0]          s1_bord, s2_bord;
  logic                    s1_v, s2_v, s1_last, s2_last;
  logic [DW-1:0]           data_nxt;

  assign adv        = !m_valid || m_ready;
  assign s_ready    = !rst && adv && (state != S_DRAIN);
  assign acc        = s_valid && s_ready;
  assign drain_slot = (state == S_DRAIN) && adv && (drain_left != '0);
  assign slot       = acc || drain_slot;
  assign slot_data  = acc ? s_data : '0;
  assign formed     = slot && (state != S_IDLE) && (slot_idx >= SLOT_W'(WPL + 1));
  assign busy       = (state != S_IDLE);

  function automatic logic signed [ACC_W-1:0] coef(input logic [1:0] m, input int r, input int c);
    logic ctr, adj;
    ctr = (r == 1) && (c == 1);
    adj = (r == 1) != (c == 1);
    case (m)
      2'd1:    coef = ctr ? ACC_W'(8) : ACC_W'(-1);
      2'd2:    coef = ctr ? ACC_W'(4) : (adj ? ACC_W'(2) : ACC_W'(1));
      2'd3:    coef = ctr ? ACC_W'(5) : (adj ? ACC_W'(-1) : ACC_W'(0));
      default: coef = '0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      mode_q     <= '0;
      slot_idx   <= '0;
      drain_left <= '0;
      oc_col     <= '0;
      oc_row     <= '0;
    end else begin
      if (slot) slot_idx <= (state == S_IDLE) ? SLOT_W'(1) : slot_idx + SLOT_W'(1);
      if (formed) begin
        if (oc_col == COL_W'(WPL - 1)) begin
          oc_col <= '0;
          oc_row <= oc_row + ROW_W'(1);
        end else begin
          oc_col <= oc_col + COL_W'(1);
        end
      end
      case (state)
        S_IDLE: if (acc) begin
          mode_q <= mode;
          oc_col <= '0;
          oc_row <= '0;
          state  <= S_RUN;
        end
        S_RUN: if (acc && slot_idx == SLOT_W'(NW - 1)) begin
          state      <= S_DRAIN;
          drain_left <= DL_W'(WPL + 1);
        end
        S_DRAIN: begin
          if (drain_slot) drain_left <= drain_left - DL_W'(1);
          if (m_valid && m_ready && m_last) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Line buffers delay by one line each; the window holds prev/cur/next words of three rows.
  always_ff @(posedge clk) begin
    if (rst) begin
      lb_ptr <= '0;
      for (int i = 0; i < WPL; i++) begin
        lb1[i] <= '0;
        lb2[i] <= '0;
      end
      for (int r = 0; r < 3; r++)
        for (int w = 0; w < 3; w++) win[r][w] <= '0;
    end else if (slot) begin
      lb1[lb_ptr] <= slot_data;
      lb2[lb_ptr] <= lb1[lb_ptr];
      lb_ptr      <= (lb_ptr == PTR_W'(WPL - 1)) ? '0 : lb_ptr + PTR_W'(1);
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb2[lb_ptr];
      win[1][2] <= lb1[lb_ptr];
      win[2][2] <= slot_data;
    end
  end

  always_comb begin
    bord_nxt = '0;
    for (int p = 0; p < PPW; p++)
      bord_nxt[p] = (oc_row == '0) || (oc_row == ROW_W'(FRAME_H - 1)) ||
                    (p == 0 && oc_col == '0) || (p == PPW - 1 && oc_col == COL_W'(WPL - 1));
  end

  always_comb begin
    for (int r = 0; r < 3; r++) rowcat[r] = {win[r][0], win[r][1], win[r][2]};
    for (int p = 0; p < PPW; p++) begin
      ctr_nxt[p] = win[1][1][DW-1-p*PIX_W -: PIX_W];
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          prod_nxt[p][r][c] = coef(mode_q, r, c) *
                              $signed(ACC_W'(rowcat[r][3*DW-1-(PPW+p+c-1)*PIX_W -: PIX_W]));
    end
  end

  always_comb begin
    data_nxt = '0;
    for (int p = 0; p < PPW; p++) begin
      tot[p]  = s2_row[p][0] + s2_row[p][1] + s2_row[p][2];
      norm[p] = (mode_q == 2'd2) ? ($signed(tot[p] + ACC_W'(8)) >>> 4) : tot[p];
      if (s2_bord[p] || mode_q == 2'd0) res[p] = s2_ctr[p];
      else if (norm[p][ACC_W-1])        res[p] = '0;
      else if (norm[p] >= PIX_MAX)      res[p] = '1;
      else                              res[p] = norm[p][PIX_W-1:0];
      data_nxt[DW-1-p*PIX_W -: PIX_W] = res[p];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_v     <= 1'b0;
      w_last  <= 1'b0;
      w_bord  <= '0;
      s1_v    <= 1'b0;
      s1_last <= 1'b0;
      s1_bord <= '0;
      s2_v    <= 1'b0;
      s2_last <= 1'b0;
      s2_bord <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
      for (int p = 0; p < PPW; p++) begin
        s1_ctr[p] <= '0;
        s2_ctr[p] <= '0;
        for (int r = 0; r < 3; r++) begin
          s2_row[p][r] <= '0;
          for (int c = 0; c < 3; c++) s1_prod[p][r][c] <= '0;
        end
      end
    end else if (adv) begin
      w_v <= formed;
      if (formed) begin
        w_last <= (oc_col == COL_W'(WPL - 1)) && (oc_row == ROW_W'(FRAME_H - 1));
        w_bord <= bord_nxt;
      end
      s1_v    <= w_v;
      s1_last <= w_last;
      s1_bord <= w_bord;
      s2_v    <= s1_v;
      s2_last <= s1_last;
      s2_bord <= s1_bord;
      m_valid <= s2_v;
      m_last  <= s2_v && s2_last;
      if (s2_v) m_data <= data_nxt;
      for (int p = 0; p < PPW; p++) begin
        s1_ctr[p] <= ctr_nxt[p];
        s2_ctr[p] <= s1_ctr[p];
        for (int r = 0; r < 3; r++) begin
          s2_row[p][r] <= s1_prod[p][r][0] + s1_prod[p][r][1] + s1_prod[p][r][2];
          for (int c = 0; c < 3; c++) s1_prod[p][r][c] <= prod_nxt[p][r][c];
        end
      end
    end
  end

endmodule

// File: tb/tb_stencil3x3_stream_filter.sv
// Bench for stencil3x3_stream_filter: directed kernel frames, randomized frames with stalls,
// and a mid-frame reset, all compared against a pixel-level reference model.
`timescale 1ns/1ps
module tb_stencil3x3_stream_filter;
  localparam int PIX_W = 8, PPW = 2, FW = 8, FH = 4;
  localparam int DW = PIX_W * PPW, WPL = FW / PPW, NW = WPL * FH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    mode = 2'd0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          m_last;
  logic          busy;

  stencil3x3_stream_filter #(.PIX_W(PIX_W), .PPW(PPW), .FRAME_W(FW), .FRAME_H(FH)) dut (
    .clk(clk), .rst(rst), .mode(mode), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0, n_fail = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Kernels in row-major order; mode 0 is the identity.
  int KERN [4][9] = '{'{0, 0, 0, 0, 1, 0, 0, 0, 0},
                      '{-1, -1, -1, -1, 8, -1, -1, -1, -1},
                      '{1, 2, 1, 2, 4, 2, 1, 2, 1},
                      '{0, -1, 0, -1, 5, -1, 0, -1, 0}};

  int img [FH][FW];
  int out_img [FH][FW];
  logic [DW:0] exp_q [$];

  function automatic int ref_pix(int r, int c, int m);
    int s;
    if (r == 0 || r == FH - 1 || c == 0 || c == FW - 1) return img[r][c];
    s = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        s += KERN[m][(dr + 1) * 3 + dc + 1] * img[r + dr][c + dc];
    if (m == 2) s = (s + 8) >>> 4;
    if (s < 0) s = 0;
    else if (s > 255) s = 255;
    return s;
  endfunction

  task automatic build_expected(input int m);
    logic [DW-1:0] w;
    int v;
    exp_q.delete();
    for (int k = 0; k < NW; k++) begin
      w = '0;
      for (int p = 0; p < PPW; p++) begin
        v = ref_pix(k / WPL, (k % WPL) * PPW + p, m);
        w[DW-1-p*PIX_W -: PIX_W] = PIX_W'(v);
      end
      exp_q.push_back({k == NW - 1, w});
    end
  endtask

  int          out_idx = 0;
  bit          mon_en = 0, prev_stall = 0, chk_busy = 0;
  logic [DW-1:0] prev_data;
  logic        prev_last;
  logic [DW:0] e_word;

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (chk_busy) begin
        check("busy_after_last", busy, 0);
        chk_busy = 0;
      end
      if (prev_stall) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, prev_data);
        check("hold_last", m_last, prev_last);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("extra_word", m_valid, 0);
        else begin
          e_word = exp_q.pop_front();
          check("data", m_data, e_word[DW-1:0]);
          check("last", m_last, e_word[DW]);
          if (out_idx < NW)
            for (int p = 0; p < PPW; p++)
              out_img[out_idx / WPL][(out_idx % WPL) * PPW + p] = m_data[DW-1-p*PIX_W -: PIX_W];
          out_idx++;
          if (m_last) chk_busy = 1;
        end
      end
    end
  end

  bit rdy_rand = 0;
  always @(posedge clk) begin
    #1;
    m_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  task automatic send_word(input logic [DW-1:0] d);
    int t;
    t = 0;
    s_data  = d;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready) begin
      t++;
      if (t > 1000) begin
        $display("FAIL send_timeout: s_ready stayed %0d, required 1", s_ready);
        $fatal(1, "input handshake stuck");
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  function automatic logic [DW-1:0] in_word(int k);
    logic [DW-1:0] w;
    w = '0;
    for (int p = 0; p < PPW; p++)
      w[DW-1-p*PIX_W -: PIX_W] = PIX_W'(img[k / WPL][(k % WPL) * PPW + p]);
    return w;
  endfunction

  task automatic wait_frame_done();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((exp_q.size() != 0 || busy) && t < 3000);
    check("frame_done", (exp_q.size() == 0 && !busy), 1);
    check("word_count", out_idx, NW);
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int m, input bit gaps, input bit scramble);
    build_expected(m);
    out_idx = 0;
    mode = 2'(m);
    for (int k = 0; k < NW; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_word(in_word(k));
      if (scramble) mode = 2'($urandom_range(0, 3));
    end
    wait_frame_done();
  endtask

  task automatic fill(input int v);
    for (int r = 0; r < FH; r++)
      for (int c = 0; c < FW; c++) img[r][c] = v;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1;

    fill(100);
    run_frame(1, 0, 0);
    check("lap_flat_int", out_img[1][3], 0);
    check("lap_flat_corner", out_img[0][0], 100);
    check("lap_flat_edge", out_img[3][7], 100);

    fill(0);
    img[1][3] = 255;
    run_frame(1, 0, 0);
    check("lap_imp_ctr", out_img[1][3], 255);
    check("lap_imp_nb", out_img[1][2], 0);
    check("lap_imp_diag", out_img[2][4], 0);
    check("lap_imp_border", out_img[0][3], 0);

    fill(100);
    run_frame(2, 0, 0);
    check("gau_flat", out_img[2][5], 100);

    fill(0);
    img[1][3] = 160;
    run_frame(2, 0, 0);
    check("gau_ctr", out_img[1][3], 40);
    check("gau_adj_h", out_img[1][4], 20);
    check("gau_adj_v", out_img[2][3], 20);
    check("gau_diag", out_img[2][4], 10);

    fill(0);
    img[1][3] = 60;
    img[0][3] = 50; img[2][3] = 50; img[1][2] = 50; img[1][4] = 50;
    img[2][5] = 10;
    img[1][5] = 50; img[3][5] = 50; img[2][4] = 50; img[2][6] = 50;
    run_frame(3, 0, 0);
    check("shp_pos", out_img[1][3], 100);
    check("shp_neg", out_img[2][5], 0);

    rdy_rand = 1;
    for (int f = 0; f < 4; f++) begin
      for (int r = 0; r < FH; r++)
        for (int c = 0; c < FW; c++) img[r][c] = $urandom_range(0, 255);
      run_frame($urandom_range(0, 3), 1, 1);
    end
    rdy_rand = 0;
    @(posedge clk);
    #1;

    for (int r = 0; r < FH; r++)
      for (int c = 0; c < FW; c++) img[r][c] = $urandom_range(0, 255);
    build_expected(1);
    out_idx = 0;
    mode = 2'd1;
    for (int k = 0; k < 7; k++) send_word(in_word(k));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    prev_stall = 0;
    chk_busy = 0;
    @(negedge clk);
    check("midrst_m_valid", m_valid, 0);
    check("midrst_busy", busy, 0);
    @(posedge clk);
    #1;

    fill(100);
    run_frame(0, 0, 0);
    check("pass_after_rst", out_img[2][3], 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
